i2c_master_1: RTL and testbench

Single-byte I2C bus master. It generates START, a 7-bit address plus R/W bit, one data byte (written or read), the ACK/NACK slots and STOP on a push-pull SCL and an open-drain SDA. It sits directly upstream of the i2c_slave_1 block and drives its scl/sda inputs, replacing hand-written bench stimulus. The user side is a one-transaction-at-a-time start/busy/done handshake.

---
 rtl/i2c_master_1_if.sv | 18 +
 rtl/i2c_master_1.sv | 117 +++++++++++
 tb/tb_i2c_master_1.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_master_1_if.sv
// i2c_master_1_if: user handshake plus SCL/SDA pins of the single-byte I2C master
interface i2c_master_1_if;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data_wr;
    logic [7:0] data_rd;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    logic       sda_oe;
    logic       sda_i;
    modport master (input start, addr, rw, data_wr, sda_i,
                    output data_rd, busy, done, ack_err, scl, sda_oe);
    modport slave  (output start, addr, rw, data_wr, sda_i,
                    input data_rd, busy, done, ack_err, scl, sda_oe);
endinterface

// File: rtl/i2c_master_1.sv
// i2c_master_1: single-byte I2C master (START, addr+rw, one data byte, ACK slots, STOP)
module i2c_master_1 #(
    parameter int CLK_DIV = 2
) (
    input logic clk,
    input logic reset,
    i2c_master_1_if.master bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_START    = 4'd1;
    localparam logic [3:0] S_ADDR     = 4'd2;
    localparam logic [3:0] S_ADDR_ACK = 4'd3;
    localparam logic [3:0] S_WRITE    = 4'd4;
    localparam logic [3:0] S_WR_ACK   = 4'd5;
    localparam logic [3:0] S_READ     = 4'd6;
    localparam logic [3:0] S_RD_NACK  = 4'd7;
    localparam logic [3:0] S_STOP     = 4'd8;
    localparam logic [7:0] DIV_MAX    = 8'(CLK_DIV - 1);

    logic [3:0] state;
    logic [7:0] div;
    logic [1:0] ph;
    logic [2:0] cnt;
    logic [7:0] tx_addr, tx_data, rd_sh, data_rd;
    logic       smp, ack_err, done;
    logic       tick, bit_end, sda_s, tx_bit, scl, sda_oe;

    assign tick    = div == DIV_MAX;
    assign bit_end = tick && ph == 2'd3;
    // with CLK_DIV=1 the sample cycle is also the tick cycle, so use the live line
    assign sda_s   = (div == 8'd0) ? bus.sda_i : smp;
    assign tx_bit  = (state == S_ADDR) ? tx_addr[cnt] : tx_data[cnt];

    // bus pins decoded from state and quarter phase; SDA only moves while SCL is low
    always_comb begin
        scl    = (state == S_IDLE || state == S_START) ? 1'b1 : ph[1];
        sda_oe = (state == S_START) ? ph[1] :
                 (state == S_STOP)  ? (ph != 2'd3) :
                 (state == S_ADDR || state == S_WRITE) ? ~tx_bit : 1'b0;
    end

    assign bus.scl     = scl;
    assign bus.sda_oe  = sda_oe;
    assign bus.busy    = state != S_IDLE;
    assign bus.done    = done;
    assign bus.ack_err = ack_err;
    assign bus.data_rd = data_rd;

    // transaction sequencer: divider, quarter phase, bit counter and bit-period state steps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            div     <= '0;
            ph      <= '0;
            cnt     <= '0;
            tx_addr <= '0;
            tx_data <= '0;
            rd_sh   <= '0;
            data_rd <= '0;
            smp     <= 1'b0;
            ack_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.start) begin
                    state   <= S_START;
                    div     <= '0;
                    ph      <= '0;
                    cnt     <= 3'd7;
                    tx_addr <= {bus.addr, bus.rw};
                    tx_data <= bus.data_wr;
                    ack_err <= 1'b0;
                end
            end else begin
                div <= tick ? 8'd0 : div + 8'd1;
                if (tick) ph <= ph + 2'd1;
                if (ph == 2'd3 && div == 8'd0) smp <= bus.sda_i;
                if (bit_end) begin
                    case (state)
                        S_START: state <= S_ADDR;
                        S_ADDR: begin
                            cnt <= cnt - 3'd1;
                            if (cnt == 3'd0) state <= S_ADDR_ACK;
                        end
                        S_ADDR_ACK: begin
                            if (sda_s) ack_err <= 1'b1;
                            state <= sda_s ? S_STOP : (tx_addr[0] ? S_READ : S_WRITE);
                        end
                        S_WRITE: begin
                            cnt <= cnt - 3'd1;
                            if (cnt == 3'd0) state <= S_WR_ACK;
                        end
                        S_WR_ACK: begin
                            if (sda_s) ack_err <= 1'b1;
                            state <= S_STOP;
                        end
                        S_READ: begin
                            rd_sh <= {rd_sh[6:0], sda_s};
                            cnt   <= cnt - 3'd1;
                            if (cnt == 3'd0) state <= S_RD_NACK;
                        end
                        S_RD_NACK: begin
                            data_rd <= rd_sh;
                            state   <= S_STOP;
                        end
                        S_STOP: begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_1.sv
// tb_i2c_master_1: directed vector bench with a behavioural I2C slave and bus monitor
module tb_i2c_master_1;
    logic clk = 1'b0;
    logic reset;
    i2c_master_1_if bus();

    i2c_master_1 #(.CLK_DIV(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wr;
        logic        ack_addr;
        logic        ack_wr;
        logic [7:0]  rd;
        logic        poke;
        logic [31:0] bits;
        int          nbits;
        int          cycles;
        logic        err;
        logic [7:0]  data_rd;
    } vec_t;

    vec_t vecs[5];
    int errors = 0;
    int checks = 0;

    // slave model controls and monitor state
    logic        m_ack_addr = 1'b1, m_ack_wr = 1'b1, m_rw = 1'b0;
    logic [7:0]  m_rd = 8'h00;
    logic        pull = 1'b0;
    logic        p_scl = 1'b1, p_sda = 1'b1;
    logic [31:0] log_bits = '0;
    int          n_bits = 0, n_start = 0, n_stop = 0, k = 0;

    assign bus.sda_i = ~(bus.sda_oe | pull);

    // monitor: logs SDA at SCL rises, counts START/STOP, and plays the slave on SCL falls
    always @(negedge clk) begin
        logic line;
        line = ~(bus.sda_oe | pull);
        if (p_scl && bus.scl && p_sda && !line) begin
            n_start++;
            k = -1;
            n_bits = 0;
            log_bits = '0;
        end
        if (p_scl && bus.scl && !p_sda && line) n_stop++;
        if (!p_scl && bus.scl) begin
            log_bits = {log_bits[30:0], line};
            n_bits++;
        end
        if (p_scl && !bus.scl) begin
            k++;
            pull = (k == 8 && m_ack_addr) ||
                   (k == 17 && !m_rw && m_ack_addr && m_ack_wr) ||
                   (m_rw && m_ack_addr && k >= 9 && k <= 16 && !m_rd[16 - k]);
        end
        p_scl = bus.scl;
        p_sda = ~(bus.sda_oe | pull);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        int cyc, s0, t0;
        s0 = n_start;
        t0 = n_stop;
        m_ack_addr = v.ack_addr;
        m_ack_wr   = v.ack_wr;
        m_rw       = v.rw;
        m_rd       = v.rd;
        bus.addr    = v.addr;
        bus.rw      = v.rw;
        bus.data_wr = v.wr;
        bus.start   = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            cyc++;
            #1;
            bus.start = v.poke && cyc == 30;
            if (v.poke && cyc == 30) begin
                bus.addr    = 7'h7F;
                bus.rw      = 1'b1;
                bus.data_wr = 8'h00;
            end
        end
        chk("cycles", cyc, v.cycles);
        chk("busy_at_done", int'(bus.busy), 0);
        chk("nbits", n_bits, v.nbits);
        chk("bits", int'(log_bits), int'(v.bits));
        chk("ack_err", int'(bus.ack_err), int'(v.err));
        chk("data_rd", int'(bus.data_rd), int'(v.data_rd));
        chk("start_edges", n_start - s0, 1);
        chk("stop_edges", n_stop - t0, 1);
    endtask

    initial begin
        vec_t v;
        int w, s0;
        //          addr   rw    wr     aA    aW    rd     poke  bits                                  n   cyc  err   data_rd
        vecs[0] = '{7'h55, 1'b0, 8'hAA, 1'b1, 1'b1, 8'h00, 1'b1, 32'(19'b1010101_0_0_10101010_0_0), 19, 161, 1'b0, 8'h00};
        vecs[1] = '{7'h21, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 32'(19'b0100001_1_0_11000011_1_0), 19, 161, 1'b0, 8'hC3};
        vecs[2] = '{7'h10, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, 32'(10'b0010000_0_1_0),            10, 89,  1'b1, 8'hC3};
        vecs[3] = '{7'h3C, 1'b0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 32'(19'b0111100_0_0_00001111_1_0), 19, 161, 1'b1, 8'hC3};
        vecs[4] = '{7'h7F, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 1'b0, 32'(19'b1111111_0_0_10000001_0_0), 19, 161, 1'b0, 8'hC3};

        reset = 1'b0;
        bus.start = 1'b0;
        bus.addr = '0;
        bus.rw = 1'b0;
        bus.data_wr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_scl", int'(bus.scl), 1);
        chk("rst_sda_oe", int'(bus.sda_oe), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_data_rd", int'(bus.data_rd), 0);
        chk("rst_ack_err", int'(bus.ack_err), 0);

        // consecutive vectors start in the done cycle of the previous one
        for (int i = 0; i < 5; i++) run(vecs[i]);

        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(bus.done), 0);
        chk("idle_busy", int'(bus.busy), 0);
        chk("idle_scl", int'(bus.scl), 1);
        chk("idle_sda_oe", int'(bus.sda_oe), 0);

        // abort with reset part way through the address byte
        s0 = n_start;
        m_ack_addr = 1'b1;
        m_rw = 1'b0;
        bus.addr = 7'h55;
        bus.rw = 1'b0;
        bus.data_wr = 8'hAA;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        w = 0;
        while ((n_start == s0 || n_bits < 3) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("mid_reach_addr", int'(w < 500), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_scl", int'(bus.scl), 1);
        chk("abort_sda_oe", int'(bus.sda_oe), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", int'(bus.done), 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        v = vecs[0];
        v.poke = 1'b0;
        run(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
